// File: rtl/pow2_signed_div_pipe.sv
// pow2_signed_div_pipe: pipelined signed divide by 2^k with floor or truncate-toward-zero rounding
module pow2_signed_div_pipe #(
    parameter int N = 8,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [SW-1:0] up_shift,
    input  logic          up_mode,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data
);
    logic adv;
    assign adv = down_ready | ~down_valid;
    assign up_ready = adv;
    genvar j;
    for (j = 0; j < SW; j++) begin : stg
        localparam int S = 1 << j;
        localparam int W = SW - j;
        logic [N-1:0] di, d;
        logic [W-1:0] ki;
        logic vi, gi, mi, ti, v, g, m, t;
        if (j == 0) begin : src
            assign {vi, di, ki, gi, mi, ti} = {up_valid, up_data, up_shift, up_data[N-1], up_mode, 1'b0};
        end else begin : src
            assign {vi, di, ki, gi, mi, ti} = {stg[j-1].v, stg[j-1].d, stg[j-1].kr.k, stg[j-1].g, stg[j-1].m, stg[j-1].t};
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v <= 1'b0;
                d <= '0;
                g <= 1'b0;
                m <= 1'b0;
                t <= 1'b0;
            end else if (adv) begin
                v <= vi;
                d <= ki[0] ? {{S{gi}}, di[N-1:S]} : di;
                g <= gi;
                m <= mi;
                t <= ti | (ki[0] & (|di[S-1:0]));
            end
        end
        // each stage consumes the lowest remaining shift bit and forwards the rest
        if (W > 1) begin : kr
            logic [W-2:0] k;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) k <= '0;
                else if (adv) k <= ki[W-1:1];
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            down_valid <= 1'b0;
            down_data <= '0;
        end else if (adv) begin
            down_valid <= stg[SW-1].v;
            down_data <= stg[SW-1].d + {{(N-1){1'b0}}, stg[SW-1].m & stg[SW-1].g & stg[SW-1].t};
        end
    end
endmodule

// File: tb/tb_pow2_signed_div_pipe.sv
// tb_pow2_signed_div_pipe: directed and randomized checks against an arithmetic division model
module tb_pow2_signed_div_pipe;
    logic clk = 1'b0;
    logic rst_n, up_valid, up_ready, up_mode, down_valid, down_ready;
    logic [7:0] up_data, down_data;
    logic [2:0] up_shift;
    int checks = 0, errors = 0, outs = 0, accepted = 0;
    logic [7:0] q[$];
    logic [7:0] last_data;
    bit stalled = 0;

    always #5 clk = ~clk;

    pow2_signed_div_pipe #(.N(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
        .up_shift(up_shift), .up_mode(up_mode),
        .down_valid(down_valid), .down_ready(down_ready), .down_data(down_data)
    );

    function automatic logic [7:0] ref_div(input logic [7:0] a, input int k, input bit m);
        int av = int'($signed(a));
        int p = 1 << k;
        int r = av / p;
        if (!m && av < 0 && (av % p) != 0) r = r - 1;
        return r[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input logic [2:0] k, input bit m, input bit r);
        bit exp_rdy;
        @(negedge clk);
        up_valid = v; up_data = d; up_shift = k; up_mode = m; down_ready = r;
        #1;
        exp_rdy = down_ready | ~down_valid;
        chk("up_ready", {31'b0, up_ready}, {31'b0, exp_rdy});
        if (stalled) begin
            chk("stall_valid", {31'b0, down_valid}, 32'd1);
            chk("stall_data", {24'b0, down_data}, {24'b0, last_data});
        end
        if (down_valid && down_ready) begin
            outs++;
            if (q.size() == 0) chk("spurious_out", {31'b0, down_valid}, 32'd0);
            else chk("stream_data", {24'b0, down_data}, {24'b0, q.pop_front()});
        end
        if (up_valid && up_ready) begin
            accepted++;
            q.push_back(ref_div(d, int'(k), m));
        end
        stalled = down_valid && !down_ready;
        last_data = down_data;
    endtask

    task automatic lat_test(input string tag, input logic [7:0] d, input logic [2:0] k, input bit m, input logic [7:0] exp);
        int n = 0;
        step(1, d, k, m, 1);
        do begin
            step(0, 8'h00, 3'd0, 0, 1);
            n++;
        end while (!down_valid && n < 12);
        chk({tag, "_latency"}, n, 32'd4);
        chk(tag, {24'b0, down_data}, {24'b0, exp});
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            step(0, 8'h00, 3'd0, 0, 1);
            n++;
        end
        chk("drain_empty", q.size(), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; up_valid = 1'b0; up_data = '0; up_shift = '0; up_mode = 1'b0; down_ready = 1'b0;
        #12;
        chk("rst_valid", {31'b0, down_valid}, 32'd0);
        chk("rst_data", {24'b0, down_data}, 32'd0);
        chk("rst_up_ready", {31'b0, up_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        lat_test("m7k1_floor", 8'hF9, 3'd1, 0, 8'hFC);
        lat_test("m7k1_trunc", 8'hF9, 3'd1, 1, 8'hFD);
        lat_test("m8k2_floor", 8'hF8, 3'd2, 0, 8'hFE);
        lat_test("m8k2_trunc", 8'hF8, 3'd2, 1, 8'hFE);
        lat_test("p7k1_floor", 8'h07, 3'd1, 0, 8'h03);
        lat_test("p7k1_trunc", 8'h07, 3'd1, 1, 8'h03);
        lat_test("p127k0", 8'h7F, 3'd0, 0, 8'h7F);
        lat_test("min_k7_floor", 8'h80, 3'd7, 0, 8'hFF);
        lat_test("min_k7_trunc", 8'h80, 3'd7, 1, 8'hFF);
        lat_test("m1k7_floor", 8'hFF, 3'd7, 0, 8'hFF);
        lat_test("m1k7_trunc", 8'hFF, 3'd7, 1, 8'h00);
        drain();

        outs = 0;
        for (int i = 0; i < 200; i++)
            step(1, 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 1);
        chk("stream_rate", outs, 32'd196);
        drain();

        accepted = 0; outs = 0;
        for (int i = 0; i < 5000 && accepted < 500; i++)
            step(1'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
        chk("bp_accepted", accepted, 32'd500);
        drain();
        chk("bp_count", outs, accepted);

        for (int i = 0; i < 4; i++)
            step(1, 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 1);
        @(negedge clk);
        up_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, down_valid}, 32'd0);
        chk("midrst_data", {24'b0, down_data}, 32'd0);
        chk("midrst_up_ready", {31'b0, up_ready}, 32'd1);
        q.delete();
        stalled = 0;
        @(negedge clk);
        rst_n = 1'b1;
        outs = 0;
        lat_test("post_rst", 8'hF9, 3'd1, 1, 8'hFD);
        for (int i = 0; i < 6; i++) step(0, 8'h00, 3'd0, 0, 1);
        chk("post_rst_outs", outs, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pow2_signed_div_pipe.md
# pow2_signed_div_pipe

Pipelined signed divider by a runtime power of two, with a selectable rounding mode: floor (the same result as an arithmetic right shift) or truncation toward zero (the same result as C-style signed division). It is built as a log-staged barrel shifter with a rounding-correction stage and a valid/ready stream handshake. It serves as a reusable arithmetic stage in streaming datapaths.

## Interface
Parameters:
- N, 8, data width in bits; must be a power of two, N >= 2.
- SW, $clog2(N), width of the shift-amount field (derived, not overridden).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- up_valid  input  1  input transaction is present.
- up_ready  output  1  block accepts the input this cycle.
- up_data  input  N  dividend, two's complement.
- up_shift  input  SW  exponent k; divisor is 2^k, with k in 0..N-1.
- up_mode  input  1  rounding mode: 0 = floor, 1 = truncate toward zero.
- down_valid  output  1  result is present.
- down_ready  input  1  consumer accepts the result.
- down_data  output  N  quotient, two's complement.

## Operation
- Pipeline structure: SW shift stages, then 1 correction stage, for L = SW+1 register stages in total.
- Shift stage j (j = 0..SW-1):
  - If shift bit j of the transaction is set, shift the data right by 2^j.
  - Fill the vacated bits with copies of the original sign bit (sign extension).
  - OR every bit shifted out into a per-transaction sticky flag.
  - The sign, mode and sticky flag travel alongside the data.
- Implementation restriction: the `>>>` and `/` operators are not used; the shifts are built from concatenation and replication only.
- Correction stage:
  - If mode = 1, the sign is 1 and sticky = 1, add 1 to the shifted value (wraps modulo 2^N).
  - Otherwise pass the shifted value through unchanged.
- Arithmetic rules:
  - Floor mode always equals a >>> k.
  - Truncate mode equals a / 2^k, rounded toward zero.
  - No overflow is possible: a = -2^(N-1) with k = N-1 gives -1 in both modes.
- Handshake:
  - A global advance is defined as adv = down_ready | ~down_valid.
  - up_ready = adv, a combinational output.
  - When adv = 1, every stage loads from its predecessor, and stage 0 loads {up_valid, payload}.
  - When adv = 0, all stages hold their contents.
  - Bubbles move through the pipe but do not collapse.
- A transfer occurs on each side only when valid & ready are both 1 at a clock edge.
- Results are delivered in order, one per accepted input; nothing is dropped or duplicated.
- Input/output rule: up_data, up_shift and up_mode are sampled only on an accepted transfer.
- down_data holds steady while down_valid = 1 and down_ready = 0.

## Timing
- Latency: an input accepted at edge t appears with down_valid = 1 after edge t+L (N = 8: L = 4), assuming no stall.
- Throughput: 1 result per cycle while down_ready = 1.
- Reset (asynchronous assert, synchronous-safe release):
  - All stage valid bits and data registers clear to 0.
  - down_valid = 0 and down_data = 0.
  - up_ready = 1 from the reset state.
- Reset during operation: all in-flight transactions are discarded. No output is produced for them after reset is released.
- Stall: with down_ready = 0 and down_valid = 1, the state is frozen and up_ready = 0. On release, the flow resumes with no loss.
- Simultaneous events: with the pipe full and down_ready = 1, an input can be accepted in the same cycle an output transfers.
- Empty pipe: down_valid = 0 and up_ready = 1 regardless of down_ready.

## Test plan
- Basic floor and truncate, N = 8:
  - up_data = 0xF9 (-7), k = 1, mode 0 -> 0xFC (-4).
  - Same input, mode 1 -> 0xFD (-3).
  - Each result arrives 4 cycles after acceptance.
- Exact and positive cases:
  - 0xF8 (-8), k = 2, both modes -> 0xFE.
  - 0x07, k = 1, both modes -> 0x03.
  - 0x7F, k = 0 -> 0x7F.
- Extremes:
  - 0x80, k = 7, both modes -> 0xFF.
  - 0xFF, k = 7: mode 0 -> 0xFF, mode 1 -> 0x00.
- Streaming against a reference model:
  - Drive 200 random {data, k, mode} back-to-back with down_ready = 1.
  - Outputs must match a >>> k and a / 2^k (floor and truncate respectively), in order, one per cycle after the 4-cycle fill.
- Backpressure:
  - Toggle down_ready randomly (50%) while up_valid is random.
  - up_ready must equal down_ready | ~down_valid.
  - down_data must be stable while stalled.
  - No loss or reordering over 500 transactions.
- Reset during operation:
  - Assert rst_n = 0 for 1 cycle with 4 items in flight.
  - down_valid must drop immediately to 0 and down_data must read 0.
  - After release, none of the old items appear, and a new input 0xF9, k = 1, mode 1 yields 0xFD after 4 cycles.
